regfile_param: RTL and testbench

Parametrised general-purpose register file for the multi-cycle CPU datapath, replacing the fixed 16-entry file. Provides two registered read ports with same-cycle write bypass, one byte-enabled write port, a registered half-word debug port for the board display, and a sequenced clear engine that zeroes the file on request without a global reset.

---
 rtl/regs_pkg.sv | 39 +++
 rtl/regfile_clr_seq.sv | 73 +++++++
 rtl/regfile_param.sv | 134 +++++++++++++
 tb/tb_regfile_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// -----------------------------------------------------------------------------
// regs_pkg
// Shared definitions for the parametrised register file:
//   - default data width and register count
//   - clear-sequencer state encoding (IDLE, CLEAR)
//   - byte_merge(): combines an old word with new data under byte enables
// -----------------------------------------------------------------------------
package regs_pkg;

    localparam int REGS_DW_DEFAULT   = 32;
    localparam int REGS_NREG_DEFAULT = 32;

    // Widest data path byte_merge() handles. Callers zero-extend their
    // operands to this width and truncate the result back to their own DW.
    localparam int MERGE_MAX_DW = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Byte lane i of the result comes from new_val when be[i] is set,
    // otherwise from old_val.
    function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
        input logic [MERGE_MAX_DW-1:0]   old_val,
        input logic [MERGE_MAX_DW-1:0]   new_val,
        input logic [MERGE_MAX_DW/8-1:0] be
    );
        logic [MERGE_MAX_DW-1:0] merged;
        merged = old_val;
        for (int i = 0; i < MERGE_MAX_DW/8; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : regs_pkg

// File: rtl/regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
// Sequencer that sweeps the register file to zero one entry per cycle.
// A clr_req_i pulse in IDLE starts a sweep of NREG cycles; requests seen
// while a sweep is running are ignored (not queued).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr_req_i  in   single-cycle clear request
//   busy_o     out  sweep in progress (registered)
//   clr_en_o   out  zero the entry at clr_idx_o this cycle
//   clr_idx_o  out  index of the entry being zeroed
// -----------------------------------------------------------------------------
module regfile_clr_seq
    import regs_pkg::*;
#(
    parameter int NREG = REGS_NREG_DEFAULT,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_idx_o
);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the values present before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy_q is set/cleared together with the state, so it always equals
    // (state_q == CLEAR) and doubles as the per-cycle clear strobe.
    assign busy_o    = busy_q;
    assign clr_en_o  = busy_q;
    assign clr_idx_o = cnt_q;

endmodule : regfile_clr_seq

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised general-purpose register file for the multi-cycle CPU.
// Two registered read ports with write-first bypass, one byte-enabled write
// port, a registered half-word debug port, and a clear sweep engine.
//
// Parameters: DW (multiple of 16), NREG (2..64), ZERO_REG (r0 hard-wired 0).
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   rnum_a/rnum_b      read indices;   rdata_a/rdata_b  registered read data
//   we/wnum/wdata/wbe  write strobe, index, data, byte enables
//   dbg_sel/dbg_half   debug index and half select; dbg_data registered half
//   clr_req            single-cycle clear request; busy  clear in progress
// -----------------------------------------------------------------------------
module regfile_param
    import regs_pkg::*;
#(
    parameter int DW       = REGS_DW_DEFAULT,
    parameter int NREG     = REGS_NREG_DEFAULT,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rnum_a,
    input  logic [AW-1:0]   rnum_b,
    output logic [DW-1:0]   rdata_a,
    output logic [DW-1:0]   rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   wnum,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wbe,
    input  logic [AW-1:0]   dbg_sel,
    input  logic            dbg_half,
    output logic [DW/2-1:0] dbg_data,
    input  logic            clr_req,
    output logic            busy
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   rdata_a_q, rdata_a_d;
    logic [DW-1:0]   rdata_b_q, rdata_b_d;
    logic [DW/2-1:0] dbg_data_q, dbg_data_d;

    logic            clr_busy;
    logic            clr_en;
    logic [AW-1:0]   clr_idx;

    logic            wr_accept;
    logic [DW-1:0]   wr_old;
    logic [DW-1:0]   wr_merged;

    regfile_clr_seq #(
        .NREG (NREG)
    ) u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (clr_req),
        .busy_o    (clr_busy),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx)
    );

    // Write qualification and byte merge. The merged word feeds both the
    // array and the read bypass.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        wr_old = '0;
        if (32'(wnum) < NREG) begin
            wr_old = regs_q[wnum];
        end
        wr_merged = DW'(byte_merge(MERGE_MAX_DW'(wr_old),
                                   MERGE_MAX_DW'(wdata),
                                   (MERGE_MAX_DW/8)'(wbe)));
        wr_accept = we && !clr_busy && (32'(wnum) < NREG)
                    && !(ZERO_REG && (wnum == '0));
    end

    // Read muxes: out-of-range and hard-wired r0 read 0; otherwise an
    // accepted write to the same index is forwarded (write-first).
    always_comb begin
        rdata_a_d = '0;
        if ((32'(rnum_a) < NREG) && !(ZERO_REG && (rnum_a == '0))) begin
            rdata_a_d = (wr_accept && (wnum == rnum_a)) ? wr_merged : regs_q[rnum_a];
        end

        rdata_b_d = '0;
        if ((32'(rnum_b) < NREG) && !(ZERO_REG && (rnum_b == '0))) begin
            rdata_b_d = (wr_accept && (wnum == rnum_b)) ? wr_merged : regs_q[rnum_b];
        end

        // Debug port shows array contents only; it never sees the bypass.
        dbg_data_d = '0;
        if (32'(dbg_sel) < NREG) begin
            dbg_data_d = dbg_half ? regs_q[dbg_sel][DW-1:DW/2]
                                  : regs_q[dbg_sel][DW/2-1:0];
        end
    end

    // Storage. Writes are blocked while the sweep runs, so the clear and
    // write paths never target the array in the same cycle.
    // NOTE: the array is reset explicitly because a reset must leave every
    // register reading 0; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_en) begin
            regs_q[clr_idx] <= '0;
        end else if (wr_accept) begin
            regs_q[wnum] <= wr_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            dbg_data_q <= '0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign dbg_data = dbg_data_q;
    assign busy     = clr_busy;

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
// Self-checking bench for regfile_param. The main instance (DW=32, NREG=32,
// ZERO_REG=1) is checked every cycle against an array model; a small
// instance (DW=16, NREG=20, ZERO_REG=0) covers out-of-range indices and a
// writable r0.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic clk;
    logic rst;

    // Main instance signals
    logic [4:0]  rnum_a, rnum_b, wnum, dbg_sel;
    logic [31:0] rdata_a, rdata_b, wdata;
    logic [3:0]  wbe;
    logic        we, dbg_half, clr_req, busy;
    logic [15:0] dbg_data;

    // Small instance signals
    logic [4:0]  s_rnum_a, s_rnum_b, s_wnum, s_dbg_sel;
    logic [15:0] s_rdata_a, s_rdata_b, s_wdata;
    logic [1:0]  s_wbe;
    logic        s_we, s_dbg_half, s_clr_req, s_busy;
    logic [7:0]  s_dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the main instance
    logic [31:0] m_mem [32];
    int          m_left;   // clear cycles still to run
    int          m_ptr;    // next entry the clear wipes

    regfile_param #(.DW(32), .NREG(32), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .rnum_a(rnum_a), .rnum_b(rnum_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .we(we), .wnum(wnum), .wdata(wdata), .wbe(wbe),
        .dbg_sel(dbg_sel), .dbg_half(dbg_half), .dbg_data(dbg_data),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_param #(.DW(16), .NREG(20), .ZERO_REG(1'b0)) u_small (
        .clk(clk), .rst(rst),
        .rnum_a(s_rnum_a), .rnum_b(s_rnum_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b),
        .we(s_we), .wnum(s_wnum), .wdata(s_wdata), .wbe(s_wbe),
        .dbg_sel(s_dbg_sel), .dbg_half(s_dbg_half), .dbg_data(s_dbg_data),
        .clr_req(s_clr_req), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_left = 0;
        m_ptr  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit acc,
                                               input logic [31:0] merged);
        if (idx == 5'd0)                return 32'h0;
        if (acc && (wnum == idx))       return merged;
        return m_mem[idx];
    endfunction

    // One clock of the main instance: predict from current inputs and model,
    // advance the model, clock, then compare.
    task automatic step();
        logic [31:0] merged, exp_a, exp_b;
        logic [15:0] exp_dbg;
        bit          was_busy, acc;
        was_busy = (m_left > 0);
        acc      = we && !was_busy && (wnum != 5'd0);
        merged   = m_mem[wnum];
        for (int b = 0; b < 4; b++) begin
            if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        exp_a   = model_read(rnum_a, acc, merged);
        exp_b   = model_read(rnum_b, acc, merged);
        exp_dbg = dbg_half ? m_mem[dbg_sel][31:16] : m_mem[dbg_sel][15:0];
        if (was_busy) begin
            m_mem[m_ptr] = '0;
            m_ptr++;
            m_left--;
        end else begin
            if (acc) m_mem[wnum] = merged;
            if (clr_req) begin
                m_left = 32;
                m_ptr  = 0;
            end
        end
        @(posedge clk);
        #1;
        check("rdata_a", rdata_a, exp_a);
        check("rdata_b", rdata_b, exp_b);
        check("dbg_data", dbg_data, exp_dbg);
        check("busy", busy, m_left > 0);
    endtask

    task automatic idle_inputs();
        we = 0; wnum = 0; wdata = 0; wbe = 0; clr_req = 0;
        rnum_a = 0; rnum_b = 0; dbg_sel = 0; dbg_half = 0;
    endtask

    task automatic write(input logic [4:0] idx, input logic [31:0] d, input logic [3:0] be);
        we = 1; wnum = idx; wdata = d; wbe = be;
    endtask

    initial begin
        int cnt;
        idle_inputs();
        s_we = 0; s_wnum = 0; s_wdata = 0; s_wbe = 0; s_clr_req = 0;
        s_rnum_a = 0; s_rnum_b = 0; s_dbg_sel = 0; s_dbg_half = 0;
        model_reset();

        // ---------------- reset ----------------
        rst = 0;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rdata_b", rdata_b, 0);
        check("rst_dbg", dbg_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst = 0;

        // ---------------- small instance ----------------
        s_we = 1; s_wnum = 0; s_wdata = 16'hA5C3; s_wbe = 2'b11;
        @(posedge clk); #1;
        s_we = 0; s_rnum_a = 0; s_rnum_b = 19;
        @(posedge clk); #1;
        check("small_r0_writable", s_rdata_a, 16'hA5C3);
        check("small_r19_reset", s_rdata_b, 0);
        s_we = 1; s_wnum = 19; s_wdata = 16'h1234; s_wbe = 2'b11;
        s_rnum_a = 19; s_rnum_b = 20;
        @(posedge clk); #1;
        check("small_bypass", s_rdata_a, 16'h1234);
        check("small_idx20", s_rdata_b, 0);
        s_wdata = 16'hFFFF; s_wbe = 2'b01; s_rnum_b = 31;
        s_dbg_sel = 19; s_dbg_half = 0;
        @(posedge clk); #1;
        check("small_bypass_be", s_rdata_a, 16'h12FF);
        check("small_idx31", s_rdata_b, 0);
        check("small_dbg_no_bypass", s_dbg_data, 8'h34);
        s_wnum = 25; s_wbe = 2'b11; s_rnum_a = 25; s_rnum_b = 19;
        @(posedge clk); #1;
        check("small_dbg_lo", s_dbg_data, 8'hFF);
        check("small_oob_write", s_rdata_a, 0);
        check("small_r19_array", s_rdata_b, 16'h12FF);
        s_we = 0; s_dbg_sel = 20; s_dbg_half = 1;
        @(posedge clk); #1;
        check("small_dbg_oob", s_dbg_data, 0);
        s_clr_req = 1;
        @(posedge clk); #1;
        s_clr_req = 0;
        cnt = 0;
        for (int i = 0; i < 100 && s_busy; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("small_busy_len", cnt, 20);
        @(posedge clk); #1;
        check("small_after_clear", s_rdata_b, 0);

        // ---------------- main directed ----------------
        write(5, 32'hDEADBEEF, 4'hF);
        step();
        idle_inputs(); rnum_a = 5; dbg_sel = 5; dbg_half = 1;
        step();
        check("r5_read", rdata_a, 32'hDEADBEEF);
        check("r5_dbg_hi", dbg_data, 16'hDEAD);
        write(5, 32'h11223344, 4'b0101);
        step();
        check("r5_be_bypass", rdata_a, 32'hDE22BE44);
        write(7, 32'h12345678, 4'hF); rnum_a = 7; rnum_b = 7;
        step();
        check("r7_bypass_a", rdata_a, 32'h12345678);
        check("r7_bypass_b", rdata_b, 32'h12345678);
        write(0, 32'hFFFFFFFF, 4'hF); rnum_a = 0; rnum_b = 5;
        step();
        check("r0_bypass", rdata_a, 0);
        check("r5_merged", rdata_b, 32'hDE22BE44);
        idle_inputs();
        step();
        check("r0_array", rdata_a, 0);

        // ---------------- clear sweep ----------------
        for (int i = 1; i < 32; i++) begin
            write(5'(i), 32'h1000_0001 + 32'(i) * 32'h0101_0101, 4'hF);
            step();
        end
        write(2, 32'h0000AAAA, 4'hF); clr_req = 1;
        step();
        clr_req = 0;
        cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            cnt++;
            write(5'($urandom_range(0, 31)), $urandom, 4'hF);
            rnum_a = 5'($urandom_range(0, 31));
            rnum_b = wnum;
            clr_req = (i == 5);
            step();
        end
        check("busy_len", cnt, 32);
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            rnum_a = 5'(i); rnum_b = 5'(31 - i);
            step();
            check("cleared_a", rdata_a, 0);
            check("cleared_b", rdata_b, 0);
        end

        // ---------------- reset during clear ----------------
        for (int i = 20; i < 26; i++) begin
            write(5'(i), 32'hA000_0000 | 32'(i), 4'hF);
            step();
        end
        idle_inputs(); clr_req = 1; rnum_a = 25; dbg_sel = 25;
        step();
        clr_req = 0;
        repeat (9) step();
        check("pre_rst_rdata_a", rdata_a, 32'hA000_0019);
        #3 rst = 1;
        #1;
        check("mid_rst_rdata_a", rdata_a, 0);
        check("mid_rst_rdata_b", rdata_b, 0);
        check("mid_rst_dbg", dbg_data, 0);
        check("mid_rst_busy", busy, 0);
        model_reset();
        @(negedge clk) rst = 0;
        write(9, 32'hCAFEF00D, 4'hF); rnum_a = 9;
        step();
        check("post_rst_write", rdata_a, 32'hCAFEF00D);
        idle_inputs(); rnum_a = 9; rnum_b = 25;
        step();
        check("post_rst_r9", rdata_a, 32'hCAFEF00D);
        check("post_rst_r25", rdata_b, 0);

        // ---------------- random ----------------
        for (int n = 0; n < 1500; n++) begin
            we       = ($urandom_range(0, 1) == 1);
            wnum     = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            wbe      = 4'($urandom_range(0, 15));
            rnum_a   = ($urandom_range(0, 3) == 0) ? wnum : 5'($urandom_range(0, 31));
            rnum_b   = 5'($urandom_range(0, 31));
            dbg_sel  = 5'($urandom_range(0, 31));
            dbg_half = ($urandom_range(0, 1) == 1);
            clr_req  = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_param
